// File: rtl/world_clock_core.sv
// -----------------------------------------------------------------------------
// world_clock_core
//   Local time-of-day clock with a set mode, 12/24 h display flag and a bank of
//   NUM_ZONES foreign time zones expressed as signed hour offsets.
//
// Optional feature macro: ALARM_EN adds a single daily alarm (hh:mm:00).
//
// Parameters
//   TICKS_PER_SEC  clock cycles per second (>= 2)
//   NUM_ZONES      number of foreign zones (1..8)
//   ZW             zone-select width, 2**ZW >= NUM_ZONES
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous active-low reset
//   run          1 = timekeeping, 0 = set mode (time frozen)
//   button[6:0]  levels: hour-, hour+, min-, min+, sec-, sec+, 12/24 toggle
//   zone_wr      strobe: store zone_off into slot zone_sel
//   zone_sel     target zone slot
//   zone_off     signed hour offset (-12..+14 accepted)
//   hour/minute/second  local time, binary
//   mode_12_24   0 = 24 h, 1 = 12 h display
//   zone_hour    per-zone hour, zone k at [5k+4:5k]
//   zone_pm      bit k set when zone k hour >= 12
//   sec_tick     one-cycle pulse on each second increment
//   changed      one-cycle refresh pulse, one cycle after a visible change
//   (ALARM_EN) alarm_wr, alarm_h, alarm_m, alarm_ack in; alarm out
// -----------------------------------------------------------------------------
module world_clock_core #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int NUM_ZONES     = 4,
  parameter int ZW            = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   run,
  input  logic [6:0]             button,
  input  logic                   zone_wr,
  input  logic [ZW-1:0]          zone_sel,
  input  logic [4:0]             zone_off,
`ifdef ALARM_EN
  input  logic                   alarm_wr,
  input  logic [4:0]             alarm_h,
  input  logic [5:0]             alarm_m,
  input  logic                   alarm_ack,
  output logic                   alarm,
`endif
  output logic [4:0]             hour,
  output logic [5:0]             minute,
  output logic [5:0]             second,
  output logic                   mode_12_24,
  output logic [5*NUM_ZONES-1:0] zone_hour,
  output logic [NUM_ZONES-1:0]   zone_pm,
  output logic                   sec_tick,
  output logic                   changed
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  // Increment with wrap to zero after max.
  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
    return (v == max) ? 6'd0 : v + 6'd1;
  endfunction

  // Decrement with wrap from zero to max.
  function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] max);
    return (v == 6'd0) ? max : v - 6'd1;
  endfunction

  // (h + off + 24) mod 24; the +24 keeps the sum positive for off >= -12.
  function automatic logic [4:0] zone_hr(input logic [4:0] h, input logic [4:0] off);
    logic [6:0] s;
    s = {2'b00, h} + {{2{off[4]}}, off} + 7'd24;
    if (s >= 7'd48) begin
      s = s - 7'd48;
    end else if (s >= 7'd24) begin
      s = s - 7'd24;
    end else begin
      s = s;
    end
    return s[4:0];
  endfunction

  logic [PW-1:0]          presc_q, presc_d;
  logic [5:0]             sec_q, sec_d;
  logic [5:0]             min_q, min_d;
  logic [4:0]             hour_q, hour_d;
  logic                   mode_q, mode_d;
  logic [6:0]             btn_q;
  logic [6:0]             rise_q;
  logic [4:0]             off_q [NUM_ZONES];
  logic [4:0]             off_d [NUM_ZONES];
  logic [5*NUM_ZONES-1:0] zone_hour_q, zone_hour_d;
  logic [NUM_ZONES-1:0]   zone_pm_q, zone_pm_d;
  logic                   sec_tick_q;
  logic                   upd_q;
  logic                   changed_q;

  logic                   tick_s;
  logic                   upd_s;
  logic                   off_ok_s;
  logic                   off_chg_s;
  logic [5:0]             h_inc_s, h_dec_s, m_inc_s, m_dec_s, s_inc_s, s_dec_s;

  // Terminal count is taken from the prescaler value alone, so a wrap that
  // coincides with run falling still advances the time.
  assign tick_s  = (presc_q == PRESC_MAX);

  assign h_inc_s = wrap_inc({1'b0, hour_q}, 6'd23);
  assign h_dec_s = wrap_dec({1'b0, hour_q}, 6'd23);
  assign m_inc_s = wrap_inc(min_q, 6'd59);
  assign m_dec_s = wrap_dec(min_q, 6'd59);
  assign s_inc_s = wrap_inc(sec_q, 6'd59);
  assign s_dec_s = wrap_dec(sec_q, 6'd59);

  // Prescaler next state: count while running, parked at zero in set mode.
  always_comb begin
    presc_d = '0;
    if (!run) begin
      presc_d = '0;
    end else if (tick_s) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Time next state: carry chain on tick, single-field adjust in set mode.
  always_comb begin
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    if (tick_s) begin
      sec_d = s_inc_s;
      if (sec_q == 6'd59) begin
        min_d = m_inc_s;
        if (min_q == 6'd59) begin
          hour_d = h_inc_s[4:0];
        end else begin
          hour_d = hour_q;
        end
      end else begin
        min_d = min_q;
      end
    end else if (!run) begin
      // Lowest-index adjust edge wins; others in the same cycle are dropped.
      if (rise_q[0]) begin
        hour_d = h_dec_s[4:0];
      end else if (rise_q[1]) begin
        hour_d = h_inc_s[4:0];
      end else if (rise_q[2]) begin
        min_d = m_dec_s;
      end else if (rise_q[3]) begin
        min_d = m_inc_s;
      end else if (rise_q[4]) begin
        sec_d = s_dec_s;
      end else if (rise_q[5]) begin
        sec_d = s_inc_s;
      end else begin
        sec_d = sec_q;
      end
    end else begin
      sec_d = sec_q;
    end
  end

  // Display mode toggles on its edge regardless of run.
  always_comb begin
    mode_d = mode_q;
    if (rise_q[6]) begin
      mode_d = ~mode_q;
    end else begin
      mode_d = mode_q;
    end
  end

  assign off_ok_s = zone_wr && (32'(zone_sel) < NUM_ZONES) &&
                    ($signed(zone_off) >= -5'sd12) && ($signed(zone_off) <= 5'sd14);

  // Offset bank next state and detection of an actual offset change.
  always_comb begin
    off_chg_s = 1'b0;
    for (int k = 0; k < NUM_ZONES; k++) begin
      off_d[k] = off_q[k];
      if (off_ok_s && (zone_sel == ZW'(k))) begin
        off_d[k] = zone_off;
        if (zone_off != off_q[k]) begin
          off_chg_s = 1'b1;
        end else begin
          off_chg_s = off_chg_s;
        end
      end else begin
        off_d[k] = off_q[k];
      end
    end
  end

  // Zone hours are derived from the current registers, hence one cycle behind.
  always_comb begin
    zone_hour_d = '0;
    zone_pm_d   = '0;
    for (int k = 0; k < NUM_ZONES; k++) begin
      zone_hour_d[5*k +: 5] = zone_hr(hour_q, off_q[k]);
      zone_pm_d[k]          = (zone_hr(hour_q, off_q[k]) >= 5'd12);
    end
  end

  assign upd_s = (sec_d != sec_q) || (min_d != min_q) || (hour_d != hour_q) ||
                 (mode_d != mode_q) || off_chg_s;

  // Main state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_q     <= '0;
      sec_q       <= 6'd0;
      min_q       <= 6'd0;
      hour_q      <= 5'd0;
      mode_q      <= 1'b0;
      btn_q       <= 7'd0;
      rise_q      <= 7'd0;
      zone_hour_q <= '0;
      zone_pm_q   <= '0;
      sec_tick_q  <= 1'b0;
      upd_q       <= 1'b0;
      changed_q   <= 1'b0;
      for (int k = 0; k < NUM_ZONES; k++) begin
        off_q[k] <= 5'd0;
      end
    end else begin
      presc_q     <= presc_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      mode_q      <= mode_d;
      btn_q       <= button;
      // Registered edge: the action reaches the outputs on the following edge.
      rise_q      <= button & ~btn_q;
      zone_hour_q <= zone_hour_d;
      zone_pm_q   <= zone_pm_d;
      sec_tick_q  <= tick_s;
      upd_q       <= upd_s;
      changed_q   <= upd_q;
      for (int k = 0; k < NUM_ZONES; k++) begin
        off_q[k] <= off_d[k];
      end
    end
  end

`ifdef ALARM_EN
  logic [4:0] al_h_q;
  logic [5:0] al_m_q;
  logic [5:0] al_cnt_q;
  logic       armed_q;
  logic       alarm_q;
  logic       al_hit_s;

  // Fires on the tick that lands exactly on the armed hh:mm:00.
  assign al_hit_s = tick_s && armed_q && (hour_d == al_h_q) &&
                    (min_d == al_m_q) && (sec_d == 6'd0);

  // Alarm setting, ring state and 60-second auto-clear counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      al_h_q   <= 5'd0;
      al_m_q   <= 6'd0;
      al_cnt_q <= 6'd0;
      armed_q  <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      if (alarm_wr) begin
        al_h_q  <= alarm_h;
        al_m_q  <= alarm_m;
        armed_q <= 1'b1;
      end else begin
        armed_q <= armed_q;
      end
      if (al_hit_s) begin
        alarm_q  <= 1'b1;
        al_cnt_q <= 6'd0;
      end else if (alarm_ack) begin
        alarm_q  <= 1'b0;
        al_cnt_q <= 6'd0;
      end else if (alarm_q && tick_s) begin
        if (al_cnt_q == 6'd59) begin
          alarm_q  <= 1'b0;
          al_cnt_q <= 6'd0;
        end else begin
          al_cnt_q <= al_cnt_q + 6'd1;
        end
      end else begin
        alarm_q <= alarm_q;
      end
    end
  end

  assign alarm = alarm_q;
`else
`endif

  assign hour       = hour_q;
  assign minute     = min_q;
  assign second     = sec_q;
  assign mode_12_24 = mode_q;
  assign zone_hour  = zone_hour_q;
  assign zone_pm    = zone_pm_q;
  assign sec_tick   = sec_tick_q;
  assign changed    = changed_q;

endmodule

// File: tb/tb_world_clock_core.sv
// Directed bench for world_clock_core with TICKS_PER_SEC=10, four zones and a
// 3-bit zone select so that an out-of-range slot index can be driven.
module tb_world_clock_core;

  logic        clock;
  logic        reset;
  logic        run;
  logic [6:0]  button;
  logic        zone_wr;
  logic [2:0]  zone_sel;
  logic [4:0]  zone_off;
  logic [4:0]  hour;
  logic [5:0]  minute;
  logic [5:0]  second;
  logic        mode_12_24;
  logic [19:0] zone_hour;
  logic [3:0]  zone_pm;
  logic        sec_tick;
  logic        changed;
`ifdef ALARM_EN
  logic        alarm_wr;
  logic [4:0]  alarm_h;
  logic [5:0]  alarm_m;
  logic        alarm_ack;
  logic        alarm;
`endif

  int tests;
  int fails;

  world_clock_core #(.TICKS_PER_SEC(10), .NUM_ZONES(4), .ZW(3)) dut (
    .clock(clock), .reset(reset), .run(run), .button(button),
    .zone_wr(zone_wr), .zone_sel(zone_sel), .zone_off(zone_off),
`ifdef ALARM_EN
    .alarm_wr(alarm_wr), .alarm_h(alarm_h), .alarm_m(alarm_m),
    .alarm_ack(alarm_ack), .alarm(alarm),
`endif
    .hour(hour), .minute(minute), .second(second), .mode_12_24(mode_12_24),
    .zone_hour(zone_hour), .zone_pm(zone_pm), .sec_tick(sec_tick), .changed(changed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic do_reset();
    reset = 1'b0; run = 1'b0; button = 7'd0; zone_wr = 1'b0;
    zone_sel = 3'd0; zone_off = 5'd0;
`ifdef ALARM_EN
    alarm_wr = 1'b0; alarm_h = 5'd0; alarm_m = 6'd0; alarm_ack = 1'b0;
`endif
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  // One-cycle press, then wait until the action and refresh pulse have passed.
  task automatic pulse_btn(input int b);
    button[b] = 1'b1;
    @(negedge clock);
    button = 7'd0;
    repeat (3) @(negedge clock);
  endtask

  task automatic wr_zone(input logic [2:0] sel, input logic [4:0] off);
    zone_sel = sel; zone_off = off; zone_wr = 1'b1;
    @(negedge clock);
    zone_wr = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({hour, minute, second, mode_12_24, sec_tick, changed} !== 20'd0) begin
      fails++; $display("FAIL reset_time: got %0d:%0d:%0d m%0d t%0d c%0d expected all 0",
                        hour, minute, second, mode_12_24, sec_tick, changed);
    end
    tests++;
    if (zone_hour !== 20'd0) begin
      fails++; $display("FAIL reset_zone_hour: got %h expected 0", zone_hour);
    end
    tests++;
    if (zone_pm !== 4'd0) begin
      fails++; $display("FAIL reset_zone_pm: got %b expected 0", zone_pm);
    end
  endtask

  task automatic test_count();
    int ticks, chg, first, sec100;
    do_reset();
    ticks = 0; chg = 0; first = -1; sec100 = -1;
    run = 1'b1;
    for (int i = 1; i <= 101; i++) begin
      @(negedge clock);
      if (sec_tick === 1'b1) begin
        ticks++;
        if (first < 0) first = i;
      end
      if (changed === 1'b1) chg++;
      if (i == 100) sec100 = int'(second);
    end
    tests++;
    if (sec100 != 10) begin
      fails++; $display("FAIL count_second: got %0d expected 10", sec100);
    end
    tests++;
    if (ticks != 10) begin
      fails++; $display("FAIL count_ticks: got %0d expected 10", ticks);
    end
    tests++;
    if (chg != 10) begin
      fails++; $display("FAIL count_changed: got %0d expected 10", chg);
    end
    tests++;
    if (first != 10) begin
      fails++; $display("FAIL first_tick_cycle: got %0d expected 10", first);
    end
    run = 1'b0;
    repeat (15) @(negedge clock);
    tests++;
    if (second !== 6'd10) begin
      fails++; $display("FAIL frozen_second: got %0d expected 10", second);
    end
    run = 1'b1;
    repeat (10) @(negedge clock);
    tests++;
    if (second !== 6'd11) begin
      fails++; $display("FAIL resume_second: got %0d expected 11", second);
    end
    run = 1'b0;
  endtask

  task automatic test_adjust();
    do_reset();
    button[0] = 1'b1;
    @(negedge clock);
    tests++;
    if (hour !== 5'd0) begin
      fails++; $display("FAIL adjust_latency: got %0d expected 0", hour);
    end
    button = 7'd0;
    @(negedge clock);
    tests++;
    if (hour !== 5'd23) begin
      fails++; $display("FAIL hour_dec_wrap: got %0d expected 23", hour);
    end
    button[5] = 1'b1;
    repeat (50) @(negedge clock);
    button = 7'd0;
    repeat (3) @(negedge clock);
    tests++;
    if ({hour, minute, second} !== {5'd23, 6'd0, 6'd1}) begin
      fails++; $display("FAIL held_sec_inc: got %0d:%0d:%0d expected 23:0:1", hour, minute, second);
    end
    button = 7'b0001010;
    @(negedge clock);
    button = 7'd0;
    repeat (3) @(negedge clock);
    tests++;
    if ({hour, minute, second} !== {5'd0, 6'd0, 6'd1}) begin
      fails++; $display("FAIL multi_edge_priority: got %0d:%0d:%0d expected 0:0:1", hour, minute, second);
    end
    pulse_btn(2);
    tests++;
    if ({hour, minute} !== {5'd0, 6'd59}) begin
      fails++; $display("FAIL min_dec_nocarry: got %0d:%0d expected 0:59", hour, minute);
    end
    run = 1'b1;
    pulse_btn(1);
    tests++;
    if (hour !== 5'd0) begin
      fails++; $display("FAIL adjust_ignored_run: got %0d expected 0", hour);
    end
    run = 1'b0;
  endtask

  task automatic test_rollover();
    int chg, ticks;
    do_reset();
    pulse_btn(0); pulse_btn(2); pulse_btn(4);
    tests++;
    if ({hour, minute, second} !== {5'd23, 6'd59, 6'd59}) begin
      fails++; $display("FAIL preload: got %0d:%0d:%0d expected 23:59:59", hour, minute, second);
    end
    chg = 0; ticks = 0;
    run = 1'b1;
    repeat (11) begin
      @(negedge clock);
      if (changed === 1'b1) chg++;
      if (sec_tick === 1'b1) ticks++;
    end
    run = 1'b0;
    tests++;
    if ({hour, minute, second} !== 17'd0) begin
      fails++; $display("FAIL rollover: got %0d:%0d:%0d expected 0:0:0", hour, minute, second);
    end
    tests++;
    if (chg != 1 || ticks != 1) begin
      fails++; $display("FAIL rollover_pulses: got changed=%0d ticks=%0d expected 1 and 1", chg, ticks);
    end
  endtask

  task automatic test_toggle();
    run = 1'b1;
    pulse_btn(6);
    tests++;
    if (mode_12_24 !== 1'b1) begin
      fails++; $display("FAIL toggle_run: got %0d expected 1", mode_12_24);
    end
    run = 1'b0;
    pulse_btn(6);
    tests++;
    if (mode_12_24 !== 1'b0) begin
      fails++; $display("FAIL toggle_set: got %0d expected 0", mode_12_24);
    end
    button[6] = 1'b1;
    repeat (20) @(negedge clock);
    button = 7'd0;
    repeat (3) @(negedge clock);
    tests++;
    if (mode_12_24 !== 1'b1) begin
      fails++; $display("FAIL toggle_held_once: got %0d expected 1", mode_12_24);
    end
  endtask

  task automatic test_zones();
    do_reset();
    repeat (5) pulse_btn(1);
    wr_zone(3'd1, 5'd10);
    tests++;
    if (zone_hour !== {5'd5, 5'd5, 5'd15, 5'd5} || zone_pm !== 4'b0010) begin
      fails++; $display("FAIL zone_write: got %h pm %b expected %h pm 0010",
                        zone_hour, zone_pm, {5'd5, 5'd5, 5'd15, 5'd5});
    end
    tests++;
    if (changed !== 1'b1) begin
      fails++; $display("FAIL zone_changed: got %0d expected 1", changed);
    end
    wr_zone(3'd1, 5'b01111);
    wr_zone(3'd5, 5'b10100);
    tests++;
    if (zone_hour !== {5'd5, 5'd5, 5'd15, 5'd5} || changed !== 1'b0) begin
      fails++; $display("FAIL zone_reject: got %h c%0d expected %h c0",
                        zone_hour, changed, {5'd5, 5'd5, 5'd15, 5'd5});
    end
    wr_zone(3'd2, 5'b10100);
    wr_zone(3'd3, 5'd14);
    wr_zone(3'd0, 5'b10011);
    tests++;
    if (zone_hour !== {5'd19, 5'd17, 5'd15, 5'd5} || zone_pm !== 4'b1110) begin
      fails++; $display("FAIL zone_bounds: got %h pm %b expected %h pm 1110",
                        zone_hour, zone_pm, {5'd19, 5'd17, 5'd15, 5'd5});
    end
    button[1] = 1'b1;
    @(negedge clock);
    button = 7'd0;
    @(negedge clock);
    tests++;
    if (hour !== 5'd6 || zone_hour !== {5'd19, 5'd17, 5'd15, 5'd5}) begin
      fails++; $display("FAIL zone_lag: got h%0d %h expected h6 %h", hour, zone_hour,
                        {5'd19, 5'd17, 5'd15, 5'd5});
    end
    @(negedge clock);
    tests++;
    if (zone_hour !== {5'd20, 5'd18, 5'd16, 5'd6}) begin
      fails++; $display("FAIL zone_follow: got %h expected %h", zone_hour, {5'd20, 5'd18, 5'd16, 5'd6});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (12) pulse_btn(0);
    repeat (26) pulse_btn(2);
    repeat (4) pulse_btn(4);
    wr_zone(3'd0, 5'd3);
    tests++;
    if ({hour, minute, second} !== {5'd12, 6'd34, 6'd56}) begin
      fails++; $display("FAIL mid_preload: got %0d:%0d:%0d expected 12:34:56", hour, minute, second);
    end
    run = 1'b1;
    repeat (9) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({hour, minute, second, mode_12_24, sec_tick, changed} !== 20'd0 ||
        zone_hour !== 20'd0 || zone_pm !== 4'd0) begin
      fails++; $display("FAIL mid_reset_clear: got %0d:%0d:%0d zh %h pm %b expected all 0",
                        hour, minute, second, zone_hour, zone_pm);
    end
    @(posedge clock);
    #1;
    tests++;
    if (sec_tick !== 1'b0 || second !== 6'd0) begin
      fails++; $display("FAIL mid_reset_tick: got tick=%0d sec=%0d expected 0 0", sec_tick, second);
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (9) @(negedge clock);
    tests++;
    if (second !== 6'd0) begin
      fails++; $display("FAIL resume_early: got %0d expected 0", second);
    end
    @(negedge clock);
    tests++;
    if ({hour, minute, second} !== {5'd0, 6'd0, 6'd1}) begin
      fails++; $display("FAIL resume_first_sec: got %0d:%0d:%0d expected 0:0:1", hour, minute, second);
    end
    run = 1'b0;
  endtask

`ifdef ALARM_EN
  task automatic test_alarm();
    int n;
    logic prev;
    do_reset();
    alarm_h = 5'd0; alarm_m = 6'd0; alarm_wr = 1'b1;
    @(negedge clock);
    alarm_wr = 1'b0;
    pulse_btn(0); pulse_btn(2); pulse_btn(4); pulse_btn(4);
    run = 1'b1;
    n = 0; prev = 1'b0;
    while (!({hour, minute, second} == 17'd0) && n < 40) begin
      prev = alarm;
      @(negedge clock);
      n++;
    end
    tests++;
    if (n >= 40 || alarm !== 1'b1 || prev !== 1'b0) begin
      fails++; $display("FAIL alarm_set: got alarm=%0d prev=%0d after %0d cycles expected 1 0", alarm, prev, n);
    end
    repeat (599) @(negedge clock);
    tests++;
    if (alarm !== 1'b1) begin
      fails++; $display("FAIL alarm_hold: got %0d expected 1", alarm);
    end
    @(negedge clock);
    tests++;
    if (alarm !== 1'b0) begin
      fails++; $display("FAIL alarm_timeout: got %0d expected 0", alarm);
    end
    alarm_m = 6'd2; alarm_wr = 1'b1;
    @(negedge clock);
    alarm_wr = 1'b0;
    n = 0;
    while (alarm !== 1'b1 && n < 700) begin
      @(negedge clock);
      n++;
    end
    tests++;
    if (n >= 700 || {hour, minute, second} !== {5'd0, 6'd2, 6'd0}) begin
      fails++; $display("FAIL alarm_second: got %0d:%0d:%0d expected 0:2:0", hour, minute, second);
    end
    alarm_ack = 1'b1;
    @(negedge clock);
    alarm_ack = 1'b0;
    tests++;
    if (alarm !== 1'b0) begin
      fails++; $display("FAIL alarm_ack: got %0d expected 0", alarm);
    end
    run = 1'b0;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_count();
    test_adjust();
    test_rollover();
    test_toggle();
    test_zones();
    test_reset_mid();
`ifdef ALARM_EN
    test_alarm();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
